ci_issue_master: RTL

Initiator side of the Nios-style multi-cycle custom-instruction (CI) interface. It accepts operand pairs on a valid/ready request port and drives start/clk_en/dataa/datab into a CI slave such as the shift unit. It waits for the slave's done pulse, captures the result and returns it on a valid/ready response port. It lets hardware accelerators and streaming engines reuse CI slaves without the Nios core.

---
 rtl/ci_issue_master_pkg.sv | 14 +
 rtl/ci_issue_master_if.sv | 33 +++
 rtl/ci_issue_master_wait_timer.sv | 27 ++
 rtl/ci_issue_master.sv | 116 +++++++++++
 4 files changed

// File: rtl/ci_issue_master_pkg.sv
// rtl/ci_issue_master_pkg.sv - shared state type and constants for the CI issue master
package ci_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ci_state_e;

    localparam int CI_DATA_W             = 32;
    localparam int CI_TIMEOUT_CYCLES_DEF = 31;

endpackage

// File: rtl/ci_issue_master_if.sv
// rtl/ci_issue_master_if.sv - request/response/CI bus bundle with master and slave views
interface ci_issue_master_if
    import ci_master_pkg::*;
#(
    parameter int DATA_W = CI_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_dataa;
    logic [DATA_W-1:0] req_datab;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_timeout;
    logic              ci_clk_en;
    logic              ci_start;
    logic [DATA_W-1:0] ci_dataa;
    logic [DATA_W-1:0] ci_datab;
    logic [DATA_W-1:0] ci_result;
    logic              ci_done;

    modport master (
        input  req_valid, req_dataa, req_datab, rsp_ready, ci_result, ci_done,
        output req_ready, rsp_valid, rsp_result, rsp_timeout,
        output ci_clk_en, ci_start, ci_dataa, ci_datab
    );

    modport slave (
        output req_valid, req_dataa, req_datab, rsp_ready, ci_result, ci_done,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout,
        input  ci_clk_en, ci_start, ci_dataa, ci_datab
    );
endinterface

// File: rtl/ci_issue_master_wait_timer.sv
// rtl/ci_issue_master_wait_timer.sv - counts WAIT cycles and flags the last cycle done is accepted
module ci_wait_timer
    import ci_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CI_TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter holds k-1 in the k-th cycle after start, so expiry marks start+TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/ci_issue_master.sv
// rtl/ci_issue_master.sv - custom-instruction initiator; CI_TIMEOUT_EN enables the done timeout
module ci_issue_master
    import ci_master_pkg::*;
#(
    parameter int DATA_W         = CI_DATA_W,
    parameter int TIMEOUT_CYCLES = CI_TIMEOUT_CYCLES_DEF,
    parameter int STAT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    ci_issue_master_if.master bus,
    output logic              busy,
    output logic [STAT_W-1:0] stat_count
);
    ci_state_e         state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              clk_en_q;
    logic              start_q;
    logic [DATA_W-1:0] dataa_q;
    logic [DATA_W-1:0] datab_q;
    logic [DATA_W-1:0] result_q;
    logic [STAT_W-1:0] stat_q;

`ifdef CI_TIMEOUT_EN
    logic timer_expired;
    logic timeout_q;

    ci_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == ISSUE),
        .enable_i (state_q == WAIT),
        .expired_o(timer_expired)
    );

    assign bus.rsp_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign bus.rsp_timeout    = 1'b0;
`endif

    // Control FSM; every bus output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            clk_en_q    <= 1'b0;
            start_q     <= 1'b0;
            dataa_q     <= '0;
            datab_q     <= '0;
            result_q    <= '0;
            stat_q      <= '0;
`ifdef CI_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        dataa_q     <= bus.req_dataa;
                        datab_q     <= bus.req_datab;
                        req_ready_q <= 1'b0;
                        start_q     <= 1'b1;
                        clk_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // clk_en stays high until completion: the slave clears its latency count when it drops.
                    start_q <= 1'b0;
                    if (bus.ci_done) begin
                        result_q    <= bus.ci_result;
                        rsp_valid_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        state_q     <= RESP;
`ifdef CI_TIMEOUT_EN
                        timeout_q   <= 1'b0;
                    end else if (timer_expired) begin
                        result_q    <= '0;
                        timeout_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        state_q     <= RESP;
`endif
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        stat_q      <= stat_q + STAT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.ci_clk_en  = clk_en_q;
    assign bus.ci_start   = start_q;
    assign bus.ci_dataa   = dataa_q;
    assign bus.ci_datab   = datab_q;
    assign busy           = (state_q != IDLE);
    assign stat_count     = stat_q;
endmodule
